// File: rtl/sya_pkg.sv
// Shared definitions for the systolic-array processing elements: default widths,
// accumulator sizing and saturation constants.
package sya_pkg;

    localparam int unsigned ActWidthDef = 8;
    localparam int unsigned WgtWidthDef = 8;
    localparam int unsigned LaneDef     = 2;
    localparam int unsigned PsumGuard   = 10;

    localparam bit SatClamp = 1'b1;
    localparam bit SatWrap  = 1'b0;

    typedef enum logic [1:0] {
        OvfNone,
        OvfPos,
        OvfNeg
    } ovf_e;

    // Guard never drops below what one dot product needs, so a single-vector tile cannot wrap.
    function automatic int unsigned psum_width(int unsigned act, int unsigned wgt,
                                               int unsigned lane);
        int unsigned dot_guard;
        dot_guard = 2 + $clog2(lane);
        return act + wgt + ((dot_guard > PsumGuard) ? dot_guard : PsumGuard);
    endfunction

endpackage

// File: rtl/sya_pe_vec_if.sv
// Operand stream, forwarded copies and result handshake of one vector PE.
interface sya_pe_vec_if #(
    parameter int unsigned ACT_WIDTH  = sya_pkg::ActWidthDef,
    parameter int unsigned WGT_WIDTH  = sya_pkg::WgtWidthDef,
    parameter int unsigned LANE       = sya_pkg::LaneDef,
    parameter int unsigned PSUM_WIDTH = sya_pkg::psum_width(ACT_WIDTH, WGT_WIDTH, LANE)
);
    logic                        in_rdy_left;
    logic                        signed_mode;
    logic                        in_vld_left;
    logic                        in_first_left;
    logic                        in_last_left;
    logic [LANE*ACT_WIDTH-1:0]   in_act_left;
    logic [LANE*WGT_WIDTH-1:0]   in_wgt_above;
    logic                        out_vld_right;
    logic                        out_first_right;
    logic                        out_last_right;
    logic [LANE*ACT_WIDTH-1:0]   out_act_right;
    logic [LANE*WGT_WIDTH-1:0]   out_wgt_below;
    logic [PSUM_WIDTH-1:0]       out_sum;
    logic                        out_sum_vld;
    logic                        out_sum_rdy;
    logic                        out_ovf;
    logic                        stall_req;

    modport master (
        output in_rdy_left, signed_mode, in_vld_left, in_first_left, in_last_left,
               in_act_left, in_wgt_above, out_sum_rdy,
        input  out_vld_right, out_first_right, out_last_right, out_act_right,
               out_wgt_below, out_sum, out_sum_vld, out_ovf, stall_req
    );

    modport slave (
        input  in_rdy_left, signed_mode, in_vld_left, in_first_left, in_last_left,
               in_act_left, in_wgt_above, out_sum_rdy,
        output out_vld_right, out_first_right, out_last_right, out_act_right,
               out_wgt_below, out_sum, out_sum_vld, out_ovf, stall_req
    );

endinterface

// File: rtl/sya_dot_lane.sv
// Combinational LANE-wide dot product of packed activations and weights,
// signed or unsigned depending on signed_mode.
module sya_dot_lane import sya_pkg::*; #(
    parameter int unsigned ACT_WIDTH = ActWidthDef,
    parameter int unsigned WGT_WIDTH = WgtWidthDef,
    parameter int unsigned LANE      = LaneDef
) (
    input  logic                                            signed_mode,
    input  logic [LANE*ACT_WIDTH-1:0]                       act,
    input  logic [LANE*WGT_WIDTH-1:0]                       wgt,
    output logic [ACT_WIDTH+WGT_WIDTH+2+$clog2(LANE)-1:0]   dot
);

    localparam int unsigned ProdW = ACT_WIDTH + WGT_WIDTH + 2;
    localparam int unsigned DotW  = ProdW + $clog2(LANE);

    // One extra bit per element lets signed and unsigned share a single signed multiplier.
    always_comb begin
        logic signed [ACT_WIDTH:0] a_x;
        logic signed [WGT_WIDTH:0] w_x;
        logic signed [ProdW-1:0]   prod;
        logic signed [DotW-1:0]    sum;
        a_x  = '0;
        w_x  = '0;
        prod = '0;
        sum  = '0;
        for (int i = 0; i < LANE; i++) begin
            a_x  = {signed_mode & act[i*ACT_WIDTH+ACT_WIDTH-1], act[i*ACT_WIDTH +: ACT_WIDTH]};
            w_x  = {signed_mode & wgt[i*WGT_WIDTH+WGT_WIDTH-1], wgt[i*WGT_WIDTH +: WGT_WIDTH]};
            prod = a_x * w_x;
            sum  = sum + DotW'(prod);
        end
        dot = sum;
    end

endmodule

// File: rtl/sya_en_reg.sv
// Enable register with asynchronous active-low clear.
module sya_en_reg #(
    parameter int unsigned Width = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [Width-1:0] d,
    output logic [Width-1:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/sya_pe_vec.sv
// Vector systolic PE: forwards operands right/down, accumulates a saturating dot-product
// partial sum, and hands finished tile sums out through a valid/ready holding register.
module sya_pe_vec import sya_pkg::*; #(
    parameter int unsigned ACT_WIDTH  = ActWidthDef,
    parameter int unsigned WGT_WIDTH  = WgtWidthDef,
    parameter int unsigned LANE       = LaneDef,
    parameter int unsigned PSUM_WIDTH = psum_width(ACT_WIDTH, WGT_WIDTH, LANE),
    parameter bit          SAT_EN     = SatClamp
) (
    input logic         clk,
    input logic         rst_n,
    sya_pe_vec_if.slave pe
);

    localparam int unsigned ActW = LANE * ACT_WIDTH;
    localparam int unsigned WgtW = LANE * WGT_WIDTH;
    localparam int unsigned StW  = 3 + ActW + WgtW;
    localparam int unsigned DotW = ACT_WIDTH + WGT_WIDTH + 2 + $clog2(LANE);
    localparam int unsigned SumW = PSUM_WIDTH + 1;

    localparam logic [PSUM_WIDTH-1:0] SMax = {1'b0, {(PSUM_WIDTH-1){1'b1}}};
    localparam logic [PSUM_WIDTH-1:0] SMin = {1'b1, {(PSUM_WIDTH-1){1'b0}}};

    logic [StW-1:0]        stage_q;
    logic                  vld_q, first_q, last_q;
    logic [ActW-1:0]       act_q;
    logic [WgtW-1:0]       wgt_q;
    logic [DotW-1:0]       dot;
    logic [SumW-1:0]       dot_x, base_x, sum_x;
    ovf_e                  ovf_kind;
    logic [PSUM_WIDTH-1:0] acc_q, acc_d;
    logic                  ovf_acc_q, ovf_acc_d;
    logic [PSUM_WIDTH-1:0] out_sum_q;
    logic                  out_ovf_q, out_sum_vld_q;
    logic                  stall, acc_en, commit, xfer;

    sya_en_reg #(
        .Width(StW)
    ) u_stage1 (
        .clk  (clk),
        .rst_n(rst_n),
        .en   (pe.in_rdy_left),
        .d    ({pe.in_vld_left, pe.in_first_left, pe.in_last_left, pe.in_act_left,
                pe.in_wgt_above}),
        .q    (stage_q)
    );

    assign {vld_q, first_q, last_q, act_q, wgt_q} = stage_q;

    sya_dot_lane #(
        .ACT_WIDTH(ACT_WIDTH),
        .WGT_WIDTH(WGT_WIDTH),
        .LANE     (LANE)
    ) u_dot (
        .signed_mode(pe.signed_mode),
        .act        (act_q),
        .wgt        (wgt_q),
        .dot        (dot)
    );

    // A pending unread result plus a last vector in stage 1 would overwrite out_sum.
    assign stall  = out_sum_vld_q & ~pe.out_sum_rdy & vld_q & last_q;
    assign acc_en = pe.in_rdy_left & vld_q & ~stall;
    assign commit = acc_en & last_q;
    assign xfer   = out_sum_vld_q & pe.out_sum_rdy;

    always_comb begin
        if (pe.signed_mode) begin
            dot_x = SumW'($signed(dot));
        end else begin
            dot_x = SumW'(dot);
        end
        base_x = first_q ? '0 : {pe.signed_mode & acc_q[PSUM_WIDTH-1], acc_q};
        sum_x  = base_x + dot_x;

        ovf_kind = OvfNone;
        if (pe.signed_mode) begin
            if (sum_x[PSUM_WIDTH] != sum_x[PSUM_WIDTH-1]) begin
                ovf_kind = sum_x[PSUM_WIDTH] ? OvfNeg : OvfPos;
            end
        end else if (sum_x[PSUM_WIDTH]) begin
            ovf_kind = OvfPos;
        end

        acc_d = sum_x[PSUM_WIDTH-1:0];
        if (SAT_EN == SatClamp) begin
            unique case (ovf_kind)
                OvfPos:  acc_d = pe.signed_mode ? SMax : '1;
                OvfNeg:  acc_d = SMin;
                default: acc_d = sum_x[PSUM_WIDTH-1:0];
            endcase
        end
        ovf_acc_d = (first_q ? 1'b0 : ovf_acc_q) | (ovf_kind != OvfNone);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q         <= '0;
            ovf_acc_q     <= 1'b0;
            out_sum_q     <= '0;
            out_ovf_q     <= 1'b0;
            out_sum_vld_q <= 1'b0;
        end else begin
            if (acc_en) begin
                acc_q     <= acc_d;
                ovf_acc_q <= ovf_acc_d;
            end
            if (commit) begin
                out_sum_q <= acc_d;
                out_ovf_q <= ovf_acc_d;
            end
            if (commit) begin
                out_sum_vld_q <= 1'b1;
            end else if (xfer) begin
                out_sum_vld_q <= 1'b0;
            end
        end
    end

    assign pe.out_vld_right   = vld_q;
    assign pe.out_first_right = first_q;
    assign pe.out_last_right  = last_q;
    assign pe.out_act_right   = act_q;
    assign pe.out_wgt_below   = wgt_q;
    assign pe.out_sum         = out_sum_q;
    assign pe.out_sum_vld     = out_sum_vld_q;
    assign pe.out_ovf         = out_ovf_q;
    assign pe.stall_req       = stall;

endmodule

// File: tb/tb_sya_pe_vec.sv
// Directed bench for sya_pe_vec: a 26-bit saturating PE plus 18-bit saturating and
// wrapping PEs sharing one stimulus stream.
module tb_sya_pe_vec;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rdy_left, sgn, v, f, l, rdy;
    logic [15:0] act, wgt;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    sya_pe_vec_if #(.ACT_WIDTH(8), .WGT_WIDTH(8), .LANE(2), .PSUM_WIDTH(26)) if26 ();
    sya_pe_vec_if #(.ACT_WIDTH(8), .WGT_WIDTH(8), .LANE(2), .PSUM_WIDTH(18)) if18s ();
    sya_pe_vec_if #(.ACT_WIDTH(8), .WGT_WIDTH(8), .LANE(2), .PSUM_WIDTH(18)) if18w ();

    assign if26.in_rdy_left    = rdy_left;  assign if18s.in_rdy_left   = rdy_left;
    assign if26.signed_mode    = sgn;       assign if18s.signed_mode   = sgn;
    assign if26.in_vld_left    = v;         assign if18s.in_vld_left   = v;
    assign if26.in_first_left  = f;         assign if18s.in_first_left = f;
    assign if26.in_last_left   = l;         assign if18s.in_last_left  = l;
    assign if26.in_act_left    = act;       assign if18s.in_act_left   = act;
    assign if26.in_wgt_above   = wgt;       assign if18s.in_wgt_above  = wgt;
    assign if26.out_sum_rdy    = rdy;       assign if18s.out_sum_rdy   = rdy;
    assign if18w.in_rdy_left   = rdy_left;  assign if18w.signed_mode   = sgn;
    assign if18w.in_vld_left   = v;         assign if18w.in_first_left = f;
    assign if18w.in_last_left  = l;         assign if18w.in_act_left   = act;
    assign if18w.in_wgt_above  = wgt;       assign if18w.out_sum_rdy   = rdy;

    sya_pe_vec #(
        .ACT_WIDTH(8), .WGT_WIDTH(8), .LANE(2), .PSUM_WIDTH(26), .SAT_EN(sya_pkg::SatClamp)
    ) u_d26 (.clk(clk), .rst_n(rst_n), .pe(if26));

    sya_pe_vec #(
        .ACT_WIDTH(8), .WGT_WIDTH(8), .LANE(2), .PSUM_WIDTH(18), .SAT_EN(sya_pkg::SatClamp)
    ) u_d18s (.clk(clk), .rst_n(rst_n), .pe(if18s));

    sya_pe_vec #(
        .ACT_WIDTH(8), .WGT_WIDTH(8), .LANE(2), .PSUM_WIDTH(18), .SAT_EN(sya_pkg::SatWrap)
    ) u_d18w (.clk(clk), .rst_n(rst_n), .pe(if18w));

    typedef struct {
        logic [7:0]  a0, a1, w0, w1;
        logic        sgn;
        logic [25:0] exp_sum;
    } vec_t;

    vec_t tbl[7];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, got, got, want,
                     want);
        end
    endtask

    // Present one vector and let one rising edge capture it.
    task automatic send(input logic [7:0] a0, a1, w0, w1, input logic ff, ll);
        act = {a1, a0};
        wgt = {w1, w0};
        v   = 1'b1;
        f   = ff;
        l   = ll;
        @(negedge clk);
    endtask

    task automatic idle();
        v = 1'b0;
        f = 1'b0;
        l = 1'b0;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, " sum"},       32'(if26.out_sum), 32'd0);
        chk({tag, " sum_vld"},   32'(if26.out_sum_vld), 32'd0);
        chk({tag, " ovf"},       32'(if26.out_ovf), 32'd0);
        chk({tag, " vld_right"}, 32'(if26.out_vld_right), 32'd0);
        chk({tag, " act_right"}, 32'(if26.out_act_right), 32'd0);
        chk({tag, " wgt_below"}, 32'(if26.out_wgt_below), 32'd0);
        chk({tag, " stall"},     32'(if26.stall_req), 32'd0);
    endtask

    initial begin
        // 26-bit negative results are stored as their two's-complement encodings.
        tbl[0] = '{8'd3,  8'hFE, 8'd4,  8'd5,  1'b1, 26'd2};
        tbl[1] = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 1'b0, 26'd130050};
        tbl[2] = '{8'h80, 8'h80, 8'h80, 8'h80, 1'b1, 26'd32768};
        tbl[3] = '{8'h7F, 8'h80, 8'd1,  8'd1,  1'b1, 26'h3FFFFFF};
        tbl[4] = '{8'hFF, 8'd0,  8'd1,  8'd2,  1'b0, 26'd255};
        tbl[5] = '{8'hFF, 8'd0,  8'd1,  8'd2,  1'b1, 26'h3FFFFFF};
        tbl[6] = '{8'h80, 8'h7F, 8'h7F, 8'h80, 1'b1, 26'h3FF8100};

        rst_n = 1'b0; rdy_left = 1'b1; sgn = 1'b1; rdy = 1'b0;
        v = 1'b1; f = 1'b1; l = 1'b1; act = 16'hFFFF; wgt = 16'hFFFF;
        repeat (2) @(negedge clk);
        chk_zero("reset");
        idle(); act = '0; wgt = '0;
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 7; i++) begin
            sgn = tbl[i].sgn;
            send(tbl[i].a0, tbl[i].a1, tbl[i].w0, tbl[i].w1, 1'b1, 1'b1);
            idle();
            @(negedge clk);
            chk($sformatf("tbl%0d sum", i), 32'(if26.out_sum), 32'(tbl[i].exp_sum));
            chk($sformatf("tbl%0d vld", i), 32'(if26.out_sum_vld), 32'd1);
            chk($sformatf("tbl%0d ovf", i), 32'(if26.out_ovf), 32'd0);
            rdy = 1'b1;
            @(negedge clk);
            chk($sformatf("tbl%0d drained", i), 32'(if26.out_sum_vld), 32'd0);
            chk($sformatf("tbl%0d hold", i), 32'(if26.out_sum), 32'(tbl[i].exp_sum));
            rdy = 1'b0;
        end

        // Four-vector tile, plus forwarding of the first vector one cycle later.
        sgn = 1'b1;
        send(8'h7F, 8'h7F, 8'h80, 8'h80, 1'b1, 1'b0);
        chk("fwd act", 32'(if26.out_act_right), 32'h7F7F);
        chk("fwd wgt", 32'(if26.out_wgt_below), 32'h8080);
        chk("fwd vld", 32'(if26.out_vld_right), 32'd1);
        chk("fwd first", 32'(if26.out_first_right), 32'd1);
        send(8'h7F, 8'h7F, 8'h80, 8'h80, 1'b0, 1'b0);
        send(8'h7F, 8'h7F, 8'h80, 8'h80, 1'b0, 1'b0);
        send(8'h7F, 8'h7F, 8'h80, 8'h80, 1'b0, 1'b1);
        chk("fwd last", 32'(if26.out_last_right), 32'd1);
        idle();
        @(negedge clk);
        chk("acc4 sum", 32'(if26.out_sum), 32'h3FE0400);  // -130048
        chk("acc4 ovf", 32'(if26.out_ovf), 32'd0);
        rdy = 1'b1; @(negedge clk); rdy = 1'b0;

        // Ten vectors of 32258 each: 322580 exceeds the 18-bit signed range.
        for (int k = 0; k < 10; k++) begin
            send(8'h7F, 8'h7F, 8'h7F, 8'h7F, (k == 0), (k == 9));
        end
        idle();
        @(negedge clk);
        chk("sat18 sum", 32'(if18s.out_sum), 32'd131071);
        chk("sat18 ovf", 32'(if18s.out_ovf), 32'd1);
        chk("wrap18 sum", 32'(if18w.out_sum), 32'd60436);  // 322580 mod 2^18
        chk("wrap18 ovf", 32'(if18w.out_ovf), 32'd1);
        chk("sat26 sum", 32'(if26.out_sum), 32'd322580);
        chk("sat26 ovf", 32'(if26.out_ovf), 32'd0);
        rdy = 1'b1; @(negedge clk); rdy = 1'b0;

        // Back-pressure: A held unread, B's last reaches stage 1.
        send(8'd3, 8'hFE, 8'd4, 8'd5, 1'b1, 1'b1);
        idle();
        @(negedge clk);
        chk("bp A sum", 32'(if26.out_sum), 32'd2);
        chk("bp A ovf18 cleared", 32'(if18s.out_ovf), 32'd0);
        send(8'd2, 8'd3, 8'd4, 8'd5, 1'b1, 1'b1);
        chk("bp stall", 32'(if26.stall_req), 32'd1);
        chk("bp A kept", 32'(if26.out_sum), 32'd2);
        rdy_left = 1'b0; idle(); rdy = 1'b1;
        #1 chk("bp stall drop", 32'(if26.stall_req), 32'd0);
        @(negedge clk);
        chk("bp A xfer vld", 32'(if26.out_sum_vld), 32'd0);
        chk("bp A xfer sum", 32'(if26.out_sum), 32'd2);
        rdy_left = 1'b1; rdy = 1'b0;
        @(negedge clk);
        chk("bp B sum", 32'(if26.out_sum), 32'd23);
        chk("bp B vld", 32'(if26.out_sum_vld), 32'd1);

        // C commits on the same edge that B transfers.
        send(8'hFF, 8'hFF, 8'd1, 8'd1, 1'b1, 1'b1);
        chk("cx stall", 32'(if26.stall_req), 32'd1);
        idle(); rdy = 1'b1;
        #1 chk("cx stall drop", 32'(if26.stall_req), 32'd0);
        @(negedge clk);
        chk("cx vld", 32'(if26.out_sum_vld), 32'd1);
        chk("cx sum", 32'(if26.out_sum), 32'h3FFFFFE);  // -2
        @(negedge clk);
        chk("cx drained", 32'(if26.out_sum_vld), 32'd0);
        rdy = 1'b0;

        // Freeze mid-tile with junk on the pins; tile total is 11 + 2 + 5.
        send(8'd1, 8'd2, 8'd3, 8'd4, 1'b1, 1'b0);
        send(8'd1, 8'd1, 8'd1, 8'd1, 1'b0, 1'b0);
        rdy_left = 1'b0;
        act = 16'hA5A5; wgt = 16'h5A5A; v = 1'b1; f = 1'b1; l = 1'b1;
        repeat (5) @(negedge clk);
        chk("frz act", 32'(if26.out_act_right), 32'h0101);
        chk("frz wgt", 32'(if26.out_wgt_below), 32'h0101);
        chk("frz first", 32'(if26.out_first_right), 32'd0);
        chk("frz last", 32'(if26.out_last_right), 32'd0);
        chk("frz no commit", 32'(if26.out_sum_vld), 32'd0);
        rdy_left = 1'b1;
        send(8'd1, 8'd0, 8'd5, 8'd0, 1'b0, 1'b1);
        idle();
        @(negedge clk);
        chk("frz sum", 32'(if26.out_sum), 32'd18);
        chk("frz vld", 32'(if26.out_sum_vld), 32'd1);

        // Reset mid-tile with an unread result pending; a later non-first last adds to 0.
        send(8'd10, 8'd10, 8'd10, 8'd10, 1'b1, 1'b0);
        send(8'd10, 8'd10, 8'd10, 8'd10, 1'b0, 1'b0);
        idle();
        rst_n = 1'b0;
        #1 chk_zero("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send(8'd1, 8'd1, 8'd1, 8'd1, 1'b0, 1'b1);
        idle();
        @(negedge clk);
        chk("post rst sum", 32'(if26.out_sum), 32'd2);
        chk("post rst vld", 32'(if26.out_sum_vld), 32'd1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
